// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
// Holds the FSM state encoding, requester count and default cell latency.
package mul_arb_pkg;

  localparam int NUM_REQ         = 2;
  localparam int DEF_MUL_LATENCY = 1;
  localparam int CNT_W           = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mul_arb_seq_rr_arb2.sv
// Two-way round-robin grant: on contention the requester
// not granted last wins; a lone requester always wins.
module rr_arb2
  import mul_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (1'b1)
      (req[0] && (!req[1] || last)):  grant = 2'b01;
      (req[1] && (!req[0] || !last)): grant = 2'b10;
      default:                        grant = '0;
    endcase
  end

endmodule

// File: rtl/mul_arb_seq.sv
// Round-robin front end sharing one external multiplier cell.
// Optional op_count flops: `define MUL_ARB_PERF_CNT_EN.
module mul_arb_seq
  import mul_arb_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int DATA_W      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_src1,
  input  logic [NUM_REQ*DATA_W-1:0] req_src2,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [DATA_W-1:0]         mul_src1,
  output logic [DATA_W-1:0]         mul_src2,
  input  logic [DATA_W-1:0]         mul_cell_result,
  output logic [31:0]               op_count
);

  state_t             state;
  state_t             state_nxt;
  logic               last_grant;
  logic               grant_idx;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               capture;
  logic               rsp_hs;
  logic               new_idx;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  assign new_idx = grant[1];
  assign accept  = (state == IDLE) && (grant != '0);
  assign capture = (state == BUSY) && (cnt == '0);
  assign rsp_hs  = (state == RESP) && rsp_ready[grant_idx];

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state)
      IDLE: begin
        if (!reset) req_ready = grant;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        if (capture) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[grant_idx] = 1'b1;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt covers the cell latency after the operand register lands;
  // the cell output is sampled once it has run down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_idx  <= 1'b0;
      cnt        <= '0;
      mul_src1   <= '0;
      mul_src2   <= '0;
      rsp_data   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= new_idx;
        grant_idx  <= new_idx;
        cnt        <= CNT_W'(MUL_LATENCY);
        mul_src1   <= new_idx ? req_src1[2*DATA_W-1:DATA_W]
                              : req_src1[DATA_W-1:0];
        mul_src2   <= new_idx ? req_src2[2*DATA_W-1:DATA_W]
                              : req_src2[DATA_W-1:0];
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) rsp_data <= mul_cell_result;
    end
  end

`ifdef MUL_ARB_PERF_CNT_EN
  logic [31:0] op_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count_q <= '0;
    end else if (rsp_hs) begin
      op_count_q <= op_count_q + 32'd1;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif

endmodule
